// File: rtl/c16_snd_pkg.sv
// Shared constants for the c16 sound unit: register codes, CTRL bit, LFSR setup, index decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package c16_snd_pkg;

    // w_param register codes
    localparam logic [1:0] SND_P_PERIOD   = 2'd0;
    localparam logic [1:0] SND_P_VOLUME   = 2'd1;
    localparam logic [1:0] SND_P_DURATION = 2'd2;
    localparam logic [1:0] SND_P_CTRL     = 2'd3;

    // CTRL: this bit set starts/restarts a channel, clear stops it
    localparam int SND_CTRL_START_BIT = 0;

    // Noise generator: x^15 + x^14 + 1
    localparam int               SND_LFSR_W    = 15;
    localparam logic [14:0]      SND_LFSR_SEED = 15'h7FFF;

    // Upper w_index bits that must be zero for a write to be accepted
    localparam logic [10:0] SND_IDX_HI_MASK = 11'h7FC;

    function automatic logic [SND_LFSR_W-1:0] snd_lfsr_next(input logic [SND_LFSR_W-1:0] s);
        return {s[SND_LFSR_W-2:0], s[14] ^ s[13]};
    endfunction

endpackage

// File: rtl/c16_snd_channel.sv
// One tone channel: period/volume/duration regs, half-period counter, duration counter, optional LFSR.
// Latency: register writes visible the cycle after the write; level is combinational from state.
// Backpressure: none, every decoded write is applied immediately.
// Ports: clk, resetn; wr_* one-hot write strobes with w_val data; tick = duration time base;
//        active = channel playing; level = current 4-bit contribution to the mix.
module c16_snd_channel
    import c16_snd_pkg::*;
#(
    parameter bit IS_NOISE = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_period,
    input  logic        wr_volume,
    input  logic        wr_duration,
    input  logic        wr_ctrl,
    input  logic [15:0] w_val,
    input  logic        tick,
    output logic        active,
    output logic [3:0]  level
);

    logic [15:0]           period;
    logic [3:0]            vol;
    logic [15:0]           duration;
    logic                  phase;
    logic [15:0]           pcnt;
    logic [15:0]           remaining;
    logic [SND_LFSR_W-1:0] lfsr;
    logic                  out_bit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period    <= '0;
            vol       <= '0;
            duration  <= '0;
            active    <= 1'b0;
            phase     <= 1'b0;
            pcnt      <= '0;
            remaining <= '0;
            lfsr      <= SND_LFSR_SEED;
        end else begin
            if (wr_period)   period   <= w_val;
            if (wr_volume)   vol      <= w_val[3:0];
            if (wr_duration) duration <= w_val;

            // A CTRL write takes priority over this cycle's counting, so a
            // restart landing on the expiry tick keeps the channel playing.
            if (wr_ctrl) begin
                if (w_val[SND_CTRL_START_BIT]) begin
                    active    <= 1'b1;
                    phase     <= 1'b1;
                    pcnt      <= period - 16'd1;
                    remaining <= duration;
                    lfsr      <= SND_LFSR_SEED;
                end else begin
                    active <= 1'b0;
                    phase  <= 1'b0;
                end
            end else if (active) begin
                // A period written mid-note is only picked up here, at reload.
                if (period != 16'd0) begin
                    if (pcnt == 16'd0) begin
                        pcnt <= period - 16'd1;
                        if (IS_NOISE) lfsr  <= snd_lfsr_next(lfsr);
                        else          phase <= ~phase;
                    end else begin
                        pcnt <= pcnt - 16'd1;
                    end
                end
                // remaining==0 means untimed; the last tick stops the note on this edge
                // (overrides any phase toggle above).
                if (tick && (remaining != 16'd0)) begin
                    remaining <= remaining - 16'd1;
                    if (remaining == 16'd1) begin
                        active <= 1'b0;
                        phase  <= 1'b0;
                    end
                end
            end
        end
    end

    assign out_bit = IS_NOISE ? lfsr[0] : phase;
    assign level   = (active && out_bit && (period != 16'd0)) ? vol : 4'd0;

endmodule

// File: rtl/c16_snd.sv
// Sound unit: decodes CPU writes into NUM_CH tone channels, mixes with saturation, drives 1-bit PWM.
// Latency: audio 1 clk after a channel level change; pwm_out 1 clk after audio.
// Backpressure: none; writes are accepted every cycle, invalid ones are dropped silently.
// Ports: clk, resetn (async, active-low); snd_wen/w_param/w_index/w_val write port;
//        audio = saturated mix, pwm_out = PWM of audio, ch_active = per-channel playing flags.
// Build option: define SND_NOISE_EN to make channel NUM_CH-1 an LFSR noise channel.
module c16_snd
    import c16_snd_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int TICK_DIV = 50000,
    parameter int OUT_W    = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              snd_wen,
    input  logic [1:0]        w_param,
    input  logic [10:0]       w_index,
    input  logic [15:0]       w_val,
    output logic [OUT_W-1:0]  audio,
    output logic              pwm_out,
    output logic [NUM_CH-1:0] ch_active
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUM_W = 4 + $clog2(NUM_CH + 1);
    localparam int AMAX  = (1 << OUT_W) - 1;

    logic [PW-1:0]    presc;
    logic             tick;
    logic             wr_ok;
    logic [3:0]       ch_level [NUM_CH];
    logic [SUM_W-1:0] sum;
    logic [OUT_W-1:0] mix;
    logic [OUT_W-1:0] pwm_cnt;

    assign tick  = (presc == PW'(TICK_DIV - 1));
    assign wr_ok = snd_wen
                && ((w_index & SND_IDX_HI_MASK) == 11'd0)
                && ({30'd0, w_index[1:0]} < 32'(NUM_CH));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
`ifdef SND_NOISE_EN
        localparam bit NOISE = (i == NUM_CH - 1);
`else
        localparam bit NOISE = 1'b0;
`endif
        logic sel;
        assign sel = wr_ok && (w_index[1:0] == 2'(i));

        c16_snd_channel #(.IS_NOISE(NOISE)) u_ch (
            .clk         (clk),
            .resetn      (resetn),
            .wr_period   (sel && (w_param == SND_P_PERIOD)),
            .wr_volume   (sel && (w_param == SND_P_VOLUME)),
            .wr_duration (sel && (w_param == SND_P_DURATION)),
            .wr_ctrl     (sel && (w_param == SND_P_CTRL)),
            .w_val       (w_val),
            .tick        (tick),
            .active      (ch_active[i]),
            .level       (ch_level[i])
        );
    end

    // Sum is wide enough for NUM_CH*15 so the clamp sees the true total.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = sum + SUM_W'(ch_level[i]);
        end
        if (32'(sum) > AMAX) mix = OUT_W'(AMAX);
        else                 mix = OUT_W'(sum);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc   <= '0;
            audio   <= '0;
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            audio   <= mix;
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < audio);
        end
    end

endmodule
